// File: rtl/keyed_lut_pkg.sv
// Shared types and width helpers for the key-locked sequential LUT core.
// The cfg word is {sel[K-1]..sel[0], mask[M-1:0]}; the offset functions below locate each field.
package keyed_lut_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Never returns less than 1 so single-entry ranges still get a real index bit.
    function automatic int clog2_f(input int value);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < value) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

    function automatic int mask_w_f(input int lut_size);
        return 32'sd1 << lut_size;
    endfunction

    function automatic int sel_lsb_f(input int lut_size, input int sel_w, input int k);
        return mask_w_f(lut_size) + k * sel_w;
    endfunction

    function automatic int cfg_w_f(input int lut_size, input int sel_w);
        return sel_lsb_f(lut_size, sel_w, lut_size);
    endfunction

endpackage

// File: rtl/keyed_lut_cell.sv
// One programmable LUT: mask/select registers, key-pad XOR, input mux and state flop.
module keyed_lut_cell
    import keyed_lut_pkg::*;
#(
    parameter int LUT_SIZE = 4,
    parameter int SEL_W    = 4,
    parameter int N_SIG    = 13,
    parameter int M        = mask_w_f(LUT_SIZE),
    parameter int CFG_W    = cfg_w_f(LUT_SIZE, SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             zero_cfg,
    input  logic             run_en,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic [M-1:0]     pad,
    input  logic [N_SIG-1:0] sig,
    output logic             q
);

    localparam int SIG_EXT_W = 32'sd1 << SEL_W;

    logic [M-1:0]                   mask_q, mask_d, mask_eff;
    logic [LUT_SIZE-1:0][SEL_W-1:0] sel_q, sel_d;
    logic [SIG_EXT_W-1:0]           sig_ext;
    logic [LUT_SIZE-1:0]            addr;
    logic                           q_q, q_d;

    // Zero-extending the signal vector makes any select >= N_SIG read 0 without a range check.
    assign sig_ext  = SIG_EXT_W'(sig);
    assign mask_eff = mask_q ^ pad;

    genvar k;
    for (k = 0; k < LUT_SIZE; k++) begin : g_addr
        assign addr[k] = sig_ext[sel_q[k]];
    end

    // Next mask/select contents and next LUT state.
    always_comb begin
        mask_d = mask_q;
        sel_d  = sel_q;
        if (zero_cfg) begin
            mask_d = '0;
            sel_d  = '0;
        end else if (wr_en) begin
            mask_d = cfg_data[M-1:0];
            for (int j = 0; j < LUT_SIZE; j++) begin
                sel_d[j] = cfg_data[sel_lsb_f(LUT_SIZE, SEL_W, j) +: SEL_W];
            end
        end else begin
            mask_d = mask_q;
            sel_d  = sel_q;
        end
        if (run_en) begin
            q_d = mask_eff[addr];
        end else begin
            q_d = 1'b0;
        end
    end

    // Configuration and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            sel_q  <= '0;
            q_q    <= 1'b0;
        end else begin
            mask_q <= mask_d;
            sel_q  <= sel_d;
            q_q    <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/keyed_lut_seq_core.sv
// Key-locked sequential LUT bank: configuration FSM, beat index, signal vector and key pad routing.
module keyed_lut_seq_core
    import keyed_lut_pkg::*;
#(
    parameter int               LUT_SIZE = 4,
    parameter int               N_LUT    = 10,
    parameter int               N_IN     = 3,
    parameter int               N_OUT    = 6,
    parameter int               KEY_W    = 32,
    parameter logic [KEY_W-1:0] KEY_VAL  = {KEY_W{1'b0}},
    parameter int               M        = mask_w_f(LUT_SIZE),
    parameter int               N_SIG    = N_IN + N_LUT,
    parameter int               SEL_W    = clog2_f(N_SIG),
    parameter int               CFG_W    = cfg_w_f(LUT_SIZE, SEL_W)
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic [KEY_W-1:0] sk,
    input  logic [N_IN-1:0]  pi,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_last,
    input  logic             cfg_clear,
    output logic             cfg_err,
    output logic             run,
    output logic [N_OUT-1:0] po
);

    localparam int               IDX_W    = clog2_f(N_LUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               run_q, run_d;
    logic               accept, abort, clear_run, run_en, zero_cfg;
    logic [KEY_W-1:0]   key_diff;
    logic [N_LUT-1:0]   q_vec;
    logic [N_SIG-1:0]   sig;

    assign accept    = cfg_valid && ready_q;
    assign clear_run = (state_q == ST_RUN) && cfg_clear;
    assign run_en    = (state_q == ST_RUN) && !cfg_clear;
    assign zero_cfg  = abort || clear_run;
    assign key_diff  = sk ^ KEY_VAL;
    assign sig       = {q_vec, pi};

    // Configuration framing: beat counting, framing errors and entry/exit of RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        abort   = 1'b0;
        case (state_q)
            ST_UNCFG, ST_LOAD: begin
                if (accept) begin
                    if (idx_q == LAST_IDX && cfg_last) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        err_d   = (state_q == ST_UNCFG) ? 1'b0 : err_q;
                    end else if (idx_q == LAST_IDX || cfg_last) begin
                        abort   = 1'b1;
                        state_d = ST_UNCFG;
                        idx_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + IDX_W'(1);
                        err_d   = (state_q == ST_UNCFG) ? 1'b0 : err_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (cfg_clear) begin
                    state_d = ST_UNCFG;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_UNCFG;
                idx_d   = '0;
            end
        endcase
        ready_d = (state_d != ST_RUN);
        run_d   = (state_d == ST_RUN);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q <= ST_UNCFG;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            run_q   <= run_d;
        end
    end

    genvar i, b;
    for (i = 0; i < N_LUT; i++) begin : g_lut
        logic [M-1:0] cell_pad;
        logic         cell_wr;

        // Mask bit b of LUT i is padded by key-difference bit (i*M + b) mod KEY_W.
        for (b = 0; b < M; b++) begin : g_pad
            localparam int PAD_BIT = (i * M + b) % KEY_W;
            assign cell_pad[b] = key_diff[PAD_BIT];
        end

        assign cell_wr = accept && (idx_q == IDX_W'(i));

        keyed_lut_cell #(
            .LUT_SIZE (LUT_SIZE),
            .SEL_W    (SEL_W),
            .N_SIG    (N_SIG),
            .M        (M),
            .CFG_W    (CFG_W)
        ) u_cell (
            .clk      (blif_clk_net),
            .rst      (blif_reset_net),
            .wr_en    (cell_wr),
            .zero_cfg (zero_cfg),
            .run_en   (run_en),
            .cfg_data (cfg_data),
            .pad      (cell_pad),
            .sig      (sig),
            .q        (q_vec[i])
        );
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign run       = run_q;
    // q is held at zero outside RUN, so the flops drive po directly.
    assign po        = q_vec[N_OUT-1:0];

endmodule

// File: tb/tb_keyed_lut_seq_core.sv
// Directed bench for keyed_lut_seq_core: vector table for single-update functions plus
// hand-written sequences for self-feedback, key change, framing errors and async reset.
module tb_keyed_lut_seq_core;

    localparam logic [31:0] KEY_VAL = 32'hC3A5_1E0F;

    logic        clk;
    logic        rst;
    logic [31:0] sk;
    logic [2:0]  pi;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic        cfg_clear;
    logic        cfg_err;
    logic        run;
    logic [5:0]  po;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [15:0] mask0;
        logic [15:0] sels0;
        logic [31:0] kx;
        logic [2:0]  pi_v;
        logic [5:0]  exp_po;
    } vec_t;

    vec_t vecs[5];

    keyed_lut_seq_core #(.KEY_VAL(KEY_VAL)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .sk             (sk),
        .pi             (pi),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .cfg_last       (cfg_last),
        .cfg_clear      (cfg_clear),
        .cfg_err        (cfg_err),
        .run            (run),
        .po             (po)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] mask, input logic [15:0] sels, input logic last);
        cfg_valid = 1'b1;
        cfg_data  = {sels, mask};
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = 32'h0;
    endtask

    // LUT0 gets mask0/sels0, every later beat is all-zero; last_at < 0 means no cfg_last.
    task automatic load(input logic [15:0] mask0, input logic [15:0] sels0,
                        input int n_beats, input int last_at);
        for (int i = 0; i < n_beats; i++) begin
            if (i == 0) beat(mask0, sels0, (i == last_at));
            else        beat(16'h0, 16'h0, (i == last_at));
        end
    endtask

    task automatic do_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        sk        = KEY_VAL;
        pi        = 3'b000;
        cfg_valid = 1'b0;
        cfg_data  = 32'h0;
        cfg_last  = 1'b0;
        cfg_clear = 1'b0;

        // AAAA with all selects on pi[0]: address 1111 -> bit 15.
        vecs[0] = '{"and_pi0",  16'hAAAA, 16'h0000, 32'h0000_0000, 3'b001, 6'b000001};
        // Pad bit 0 hits LUT0/2/4 mask bit 0 (i*16 mod 32 == 0 for even i).
        vecs[1] = '{"pad_bit0", 16'hAAAA, 16'h0000, 32'h0000_0001, 3'b000, 6'b010101};
        // sel3=13 is out of range (reads 0): address 0011 -> bit 3 of 0x96.
        vecs[2] = '{"oor13",    16'h0096, 16'hD210, 32'h0000_0000, 3'b011, 6'b000000};
        // sel3=15 out of range: address 0111 -> bit 7 of 0x96.
        vecs[3] = '{"oor15",    16'h0096, 16'hF210, 32'h0000_0000, 3'b111, 6'b000001};
        // Pad bit 16 hits mask bit 0 of the odd LUTs.
        vecs[4] = '{"pad_mod",  16'h0000, 16'h0000, 32'h0001_0000, 3'b000, 6'b101010};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_run",   32'(run),       32'd0);
        check("rst_po",    32'(po),        32'd0);
        check("rst_err",   32'(cfg_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            sk = KEY_VAL ^ vecs[v].kx;
            pi = vecs[v].pi_v;
            load(vecs[v].mask0, vecs[v].sels0, 10, 9);
            check({vecs[v].name, "_run"},   32'(run),       32'd1);
            check({vecs[v].name, "_po0"},   32'(po),        32'd0);
            tick();
            check({vecs[v].name, "_po"},    32'(po),        32'(vecs[v].exp_po));
            do_clear();
            check({vecs[v].name, "_clrpo"}, 32'(po),        32'd0);
            check({vecs[v].name, "_clrrd"}, 32'(cfg_ready), 32'd1);
            check({vecs[v].name, "_clrrn"}, 32'(run),       32'd0);
        end

        // Self-feedback: 5555 with sel0 = S[3] = q[0] toggles q[0].
        sk = KEY_VAL;
        pi = 3'b000;
        load(16'h5555, 16'h0003, 10, 9);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("toggle", 32'(po), (t % 2 == 0) ? 32'd1 : 32'd0);
        end
        // Key change only lands on the next update edge.
        sk = KEY_VAL ^ 32'h0000_0001;
        #1;
        check("key_hold", 32'(po), 32'd0);
        tick();
        check("key_next", 32'(po), 32'(6'b010100));
        do_clear();
        sk = KEY_VAL;

        // Early cfg_last on beat 4.
        load(16'hAAAA, 16'h0000, 4, 3);
        check("short_err",   32'(cfg_err),   32'd1);
        check("short_ready", 32'(cfg_ready), 32'd1);
        check("short_run",   32'(run),       32'd0);
        beat(16'hAAAA, 16'h0000, 1'b0);
        check("reload_errclr", 32'(cfg_err), 32'd0);
        check("reload_load",   32'(run),     32'd0);
        for (int i = 1; i < 10; i++) beat(16'h0, 16'h0, (i == 9));
        check("reload_run", 32'(run),     32'd1);
        check("reload_err", 32'(cfg_err), 32'd0);
        do_clear();

        // Ten beats without cfg_last.
        load(16'h0, 16'h0, 10, -1);
        check("nolast_err",   32'(cfg_err),   32'd1);
        check("nolast_run",   32'(run),       32'd0);
        check("nolast_ready", 32'(cfg_ready), 32'd1);

        // Async reset mid-LOAD after beat 6.
        load(16'hAAAA, 16'h0000, 6, -1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_load_ready", 32'(cfg_ready), 32'd1);
        check("mid_load_run",   32'(run),       32'd0);
        check("mid_load_err",   32'(cfg_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-RUN.
        pi = 3'b001;
        load(16'hAAAA, 16'h0000, 10, 9);
        tick();
        check("pre_rst_po", 32'(po), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_run_po",    32'(po),        32'd0);
        check("mid_run_run",   32'(run),       32'd0);
        check("mid_run_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
